prog_timer: RTL

Parametrised programmable interval timer, the successor to the fixed 14-bit delay counter. Adds a prescaler, explicit start/stop control, latched configuration, and three modes: periodic, one-shot and retriggerable watchdog. Sits beside control FSMs that need delays, periodic strobes or timeout supervision. Emits a single-cycle `time_out` pulse per expiry, plus status outputs.

---
 rtl/prog_timer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/prog_timer.sv
// Programmable interval timer: prescaled tick counter with periodic, one-shot and
// watchdog modes. Emits a one-cycle registered time_out pulse on each expiry.
module prog_timer #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic             time_out,
    output logic             busy,
    output logic             expired,
    output logic [WIDTH-1:0] count_out
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0] ModePeriodic = 2'b00;
    localparam logic [1:0] ModeOneShot  = 2'b01;
    localparam logic [1:0] ModeWatchdog = 2'b10;
    localparam logic [1:0] ModeOff      = 2'b11;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [1:0]         mode_q, mode_d;
    logic               time_out_q, time_out_d;
    logic               expired_q, expired_d;
    logic               start_acc;
    logic               tick;

    // A running one-shot cannot be retriggered; mode 11 never arms.
    assign start_acc = start && (mode != ModeOff) &&
                       ((state_q == StIdle) || (mode_q != ModeOneShot));
    assign tick      = (state_q == StRun) && enable && (pre_cnt_q == pre_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_cnt_d  = pre_cnt_q;
        period_d   = period_q;
        pre_d      = pre_q;
        mode_d     = mode_q;
        time_out_d = 1'b0;
        expired_d  = expired_q;

        if (stop) begin
            state_d   = StIdle;
            count_d   = '0;
            pre_cnt_d = '0;
            expired_d = 1'b0;
        end else if (start_acc) begin
            state_d   = StRun;
            period_d  = period;
            pre_d     = prescale;
            mode_d    = mode;
            count_d   = '0;
            pre_cnt_d = '0;
            expired_d = 1'b0;
        end else if (state_q == StRun && enable) begin
            if (!tick) begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end else begin
                pre_cnt_d = '0;
                if (count_q != period_q) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    time_out_d = 1'b1;
                    count_d    = '0;
                    case (mode_q)
                        ModePeriodic: begin
                            // Retune only at the period boundary.
                            period_d = period;
                            pre_d    = prescale;
                        end
                        ModeWatchdog: begin
                            state_d   = StIdle;
                            expired_d = 1'b1;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            pre_cnt_q  <= '0;
            period_q   <= '0;
            pre_q      <= '0;
            mode_q     <= ModePeriodic;
            time_out_q <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pre_cnt_q  <= pre_cnt_d;
            period_q   <= period_d;
            pre_q      <= pre_d;
            mode_q     <= mode_d;
            time_out_q <= time_out_d;
            expired_q  <= expired_d;
        end
    end

    assign time_out  = time_out_q;
    assign busy      = (state_q == StRun);
    assign expired   = expired_q;
    assign count_out = count_q;

endmodule
